// File: rtl/step_move_ctrl.sv
// Stepper move sequencer: accepts a move command, ramps the prescaler rate code up to the
// target and back to zero, counts steps, and handles reversal settle and controlled abort.
module step_move_ctrl #(
  parameter int CNT_W      = 16,
  parameter int RAMP_STEPS = 8,
  parameter int SETTLE_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [2:0]       cmd_rate,
  input  logic             abort,
  input  logic             step_tick,
  output logic             rot_en,
  output logic             rot_dir,
  output logic [2:0]       set_rate,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [2:0] {IDLE, SETTLE, ACCEL, CRUISE, DECEL} state_t;

  localparam int RC_W = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TH_W = CNT_W + 3;
  localparam logic [RC_W-1:0] RAMP_LAST   = RC_W'(RAMP_STEPS - 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
  localparam logic [TH_W-1:0] RAMP_MULT   = TH_W'(RAMP_STEPS);

  state_t           state, state_d;
  logic             last_dir, last_dir_d;
  logic             abort_flag, abort_flag_d;
  logic [RC_W-1:0]  ramp_cnt, ramp_cnt_d;
  logic [SC_W-1:0]  settle_cnt, settle_cnt_d;
  logic [2:0]       target, target_d, set_rate_d;
  logic             rot_dir_d, done_d, aborted_d;
  logic [CNT_W-1:0] steps_left_d, steps_next;
  logic [TH_W-1:0]  decel_thresh;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state;
    last_dir_d   = last_dir;
    abort_flag_d = abort_flag;
    ramp_cnt_d   = ramp_cnt;
    settle_cnt_d = settle_cnt;
    target_d     = target;
    set_rate_d   = set_rate;
    rot_dir_d    = rot_dir;
    steps_left_d = steps_left;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    steps_next   = steps_left - CNT_W'(1);
    // Widened so the ramp-down distance never wraps for large RAMP_STEPS.
    decel_thresh = TH_W'(set_rate) * RAMP_MULT;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          steps_left_d = cmd_steps;
          rot_dir_d    = cmd_dir;
          last_dir_d   = cmd_dir;
          target_d     = cmd_rate;
          set_rate_d   = 3'd0;
          ramp_cnt_d   = '0;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else if (cmd_dir != last_dir) begin
            state_d      = SETTLE;
            settle_cnt_d = SETTLE_LAST;
          end else begin
            state_d = ACCEL;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (settle_cnt == '0) begin
          state_d = ACCEL;
        end else begin
          settle_cnt_d = settle_cnt - SC_W'(1);
        end
      end
      default: begin
        if (step_tick) begin
          steps_left_d = steps_next;
          if (steps_next == '0) begin
            state_d    = IDLE;
            set_rate_d = 3'd0;
            done_d     = 1'b1;
          end else if (abort_flag) begin
            // Controlled stop: one level down every RAMP_STEPS ticks, then halt at rate 0.
            if (set_rate == 3'd0) begin
              state_d   = IDLE;
              aborted_d = 1'b1;
            end else if (ramp_cnt == RAMP_LAST) begin
              set_rate_d = set_rate - 3'd1;
              ramp_cnt_d = '0;
            end else begin
              ramp_cnt_d = ramp_cnt + RC_W'(1);
            end
          end else if (abort) begin
            abort_flag_d = 1'b1;
            state_d      = DECEL;
            ramp_cnt_d   = '0;
          end else if (set_rate != 3'd0 && {3'b000, steps_next} <= decel_thresh) begin
            set_rate_d = set_rate - 3'd1;
            state_d    = DECEL;
          end else if (state == ACCEL) begin
            if (ramp_cnt == RAMP_LAST) begin
              ramp_cnt_d = '0;
              if (set_rate < target) set_rate_d = set_rate + 3'd1;
            end else begin
              ramp_cnt_d = ramp_cnt + RC_W'(1);
            end
            if (set_rate_d >= target) state_d = CRUISE;
          end
        end else if (abort && !abort_flag) begin
          abort_flag_d = 1'b1;
          state_d      = DECEL;
          ramp_cnt_d   = '0;
        end
      end
    endcase

    if (state_d == IDLE) abort_flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_dir   <= 1'b0;
      abort_flag <= 1'b0;
      ramp_cnt   <= '0;
      settle_cnt <= '0;
      target     <= 3'd0;
      cmd_ready  <= 1'b1;
      rot_en     <= 1'b0;
      rot_dir    <= 1'b0;
      set_rate   <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      steps_left <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state      <= state_d;
      last_dir   <= last_dir_d;
      abort_flag <= abort_flag_d;
      ramp_cnt   <= ramp_cnt_d;
      settle_cnt <= settle_cnt_d;
      target     <= target_d;
      cmd_ready  <= (state_d == IDLE);
      rot_en     <= (state_d == ACCEL) || (state_d == CRUISE) || (state_d == DECEL);
      rot_dir    <= rot_dir_d;
      set_rate   <= set_rate_d;
      busy       <= (state_d != IDLE);
      done       <= done_d;
      aborted    <= aborted_d;
      steps_left <= steps_left_d;
    end
  end

endmodule

// File: tb/tb_step_move_ctrl.sv
// Bench for step_move_ctrl: table of single-move checkpoints, hand-written settle/abort/reset
// sequences, and random moves compared against a per-move rate-profile model.
module tb_step_move_ctrl;

  localparam int CNT_W  = 16;
  localparam int R      = 8;
  localparam int SETTLE = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic [2:0]       cmd_rate = 3'd0;
  logic             abort = 1'b0;
  logic             step_tick = 1'b0;
  logic             rot_en, rot_dir, busy, done, aborted;
  logic [2:0]       set_rate;
  logic [CNT_W-1:0] steps_left;

  int n_tests = 0;
  int n_fail  = 0;
  bit last_dir_m = 1'b0;

  int exp_rates[$];
  bit exp_by_abort;

  step_move_ctrl #(.CNT_W(CNT_W), .RAMP_STEPS(R), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_rate(cmd_rate), .abort(abort), .step_tick(step_tick),
    .rot_en(rot_en), .rot_dir(rot_dir), .set_rate(set_rate), .busy(busy), .done(done),
    .aborted(aborted), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit dir, input int steps, input int rate);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = CNT_W'(steps);
    cmd_rate  = 3'(rate);
    step();
    cmd_valid  = 1'b0;
    last_dir_m = dir;
  endtask

  task automatic tick();
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
  endtask

  // Edges until rot_en is seen high, or -1 when it never rises within the budget.
  task automatic wait_moving(output int edges);
    edges = 0;
    while (!rot_en && edges < 4 * SETTLE) begin
      step();
      edges++;
    end
    if (!rot_en) edges = -1;
  endtask

  task automatic finish_move(input string name);
    int guard;
    guard = int'(steps_left) + 4;
    while (busy && guard > 0) begin
      tick();
      guard--;
    end
    check({name, " ended"}, int'(busy), 0);
    check({name, " done"}, int'(done), 1);
    step();
  endtask

  // Rate after each tick of one move, from the ramp rules applied to whole-move counters.
  function automatic void plan(input int n_steps, input int tgt, input int abort_after);
    int  r, left, dwell;
    bit  stopping, slowing;
    r = 0; left = n_steps; dwell = 0; stopping = 0; slowing = 0;
    exp_rates.delete();
    exp_by_abort = 1'b0;
    for (int k = 1; k <= n_steps; k++) begin
      if (k - 1 == abort_after) begin
        stopping = 1'b1;
        dwell    = 0;
      end
      left--;
      if (left == 0) begin
        exp_rates.push_back(0);
        return;
      end
      if (stopping) begin
        if (r == 0) begin
          exp_rates.push_back(0);
          exp_by_abort = 1'b1;
          return;
        end
        dwell++;
        if (dwell == R) begin r--; dwell = 0; end
      end else if (r > 0 && left <= r * R) begin
        r--;
        slowing = 1'b1;
      end else if (!slowing && r < tgt) begin
        dwell++;
        if (dwell == R) begin r++; dwell = 0; end
      end
      exp_rates.push_back(r);
    end
  endfunction

  typedef struct {
    int steps;
    int rate;
    int ticks;
    int exp_rate;
    int exp_left;
    int exp_busy;
    int exp_done;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int  edges;
    bit  early;

    vecs = '{
      '{4,   7, 3,   0, 1,  1, 0},
      '{4,   7, 4,   0, 0,  0, 1},
      '{100, 2, 7,   0, 93, 1, 0},
      '{100, 2, 8,   1, 92, 1, 0},
      '{100, 2, 16,  2, 84, 1, 0},
      '{100, 2, 83,  2, 17, 1, 0},
      '{100, 2, 84,  1, 16, 1, 0},
      '{100, 2, 92,  0, 8,  1, 0},
      '{100, 2, 100, 0, 0,  0, 1},
      '{20,  7, 8,   1, 12, 1, 0},
      '{20,  7, 11,  1, 9,  1, 0},
      '{20,  7, 12,  0, 8,  1, 0},
      '{20,  7, 20,  0, 0,  0, 1},
      '{15,  7, 9,   0, 6,  1, 0},
      '{0,   3, 0,   0, 0,  0, 1}
    };

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset cmd_ready", int'(cmd_ready), 1);
    check("reset rot_en", int'(rot_en), 0);
    check("reset rot_dir", int'(rot_dir), 0);
    check("reset set_rate", int'(set_rate), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset aborted", int'(aborted), 0);
    check("reset steps_left", int'(steps_left), 0);
    rst = 1'b1;
    step();

    // Table: one move per record, checked after the given number of ticks
    for (int i = 0; i < 15; i++) begin
      send_cmd(1'b0, vecs[i].steps, vecs[i].rate);
      for (int k = 0; k < vecs[i].ticks; k++) tick();
      check($sformatf("vec%0d set_rate", i), int'(set_rate), vecs[i].exp_rate);
      check($sformatf("vec%0d steps_left", i), int'(steps_left), vecs[i].exp_left);
      check($sformatf("vec%0d busy", i), int'(busy), vecs[i].exp_busy);
      check($sformatf("vec%0d done", i), int'(done), vecs[i].exp_done);
      if (busy) finish_move($sformatf("vec%0d", i));
      else step();
    end

    // Reversal: settle with ticks ignored
    send_cmd(1'b1, 5, 1);
    check("settle rot_dir", int'(rot_dir), 1);
    check("settle rot_en at accept", int'(rot_en), 0);
    check("settle cmd_ready", int'(cmd_ready), 0);
    early = 1'b0;
    step_tick = 1'b1;
    for (int c = 1; c < SETTLE; c++) begin
      step();
      if (rot_en) early = 1'b1;
    end
    check("settle rot_en early", int'(early), 0);
    step();
    step_tick = 1'b0;
    check("settle rot_en rises", int'(rot_en), 1);
    check("settle ticks ignored", int'(steps_left), 5);
    finish_move("settle move");

    // Abort during a second settle
    send_cmd(1'b0, 50, 3);
    check("settle2 rot_en", int'(rot_en), 0);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("settle abort pulse", int'(aborted), 1);
    check("settle abort busy", int'(busy), 0);
    check("settle abort done", int'(done), 0);
    check("settle abort steps_left", int'(steps_left), 50);
    step();
    check("settle abort pulse width", int'(aborted), 0);
    check("settle abort cmd_ready", int'(cmd_ready), 1);

    // Abort in CRUISE at rate 2 with 500 steps left
    send_cmd(1'b0, 600, 2);
    for (int k = 0; k < 100; k++) tick();
    check("cruise rate", int'(set_rate), 2);
    check("cruise steps_left", int'(steps_left), 500);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("cruise abort busy", int'(busy), 1);
    for (int k = 0; k < 8; k++) tick();
    check("cruise abort rate after 8", int'(set_rate), 1);
    for (int k = 0; k < 8; k++) tick();
    check("cruise abort rate after 16", int'(set_rate), 0);
    check("cruise abort still moving", int'(rot_en), 1);
    tick();
    check("cruise abort pulse", int'(aborted), 1);
    check("cruise abort no done", int'(done), 0);
    check("cruise abort rot_en", int'(rot_en), 0);
    check("cruise abort steps_left", int'(steps_left), 483);
    step();

    // Abort arriving with the final tick: done wins
    send_cmd(1'b0, 3, 1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("final tick done", int'(done), 1);
    check("final tick no abort", int'(aborted), 0);
    check("final tick steps_left", int'(steps_left), 0);
    step();

    // Abort in IDLE is ignored and the concurrent command is accepted
    abort = 1'b1;
    send_cmd(1'b0, 2, 5);
    abort = 1'b0;
    check("idle abort busy", int'(busy), 1);
    check("idle abort no pulse", int'(aborted), 0);
    tick();
    tick();
    check("idle abort move done", int'(done), 1);
    step();

    // Random moves against the rate-profile model
    for (int m = 0; m < 40; m++) begin
      int ns, rt, ab;
      bit d, need_settle;
      ns = $urandom_range(0, 60);
      rt = $urandom_range(0, 7);
      d  = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0 && ns > 0) ? $urandom_range(0, ns - 1) : -1;
      need_settle = (ns != 0) && (d != last_dir_m);
      plan(ns, rt, ab);
      send_cmd(d, ns, rt);
      if (ns == 0) begin
        check($sformatf("rnd%0d zero done", m), int'(done), 1);
        check($sformatf("rnd%0d zero busy", m), int'(busy), 0);
        step();
        continue;
      end
      check($sformatf("rnd%0d rot_dir", m), int'(rot_dir), int'(d));
      if (need_settle) begin
        wait_moving(edges);
        check($sformatf("rnd%0d settle edges", m), edges, SETTLE);
      end else begin
        check($sformatf("rnd%0d rot_en at accept", m), int'(rot_en), 1);
      end
      if (!rot_en) continue;
      for (int k = 1; k <= exp_rates.size(); k++) begin
        if (k - 1 == ab) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          check($sformatf("rnd%0d abort busy", m), int'(busy), 1);
        end
        repeat ($urandom_range(0, 2)) step();
        tick();
        check($sformatf("rnd%0d tick%0d set_rate", m, k), int'(set_rate), exp_rates[k-1]);
        check($sformatf("rnd%0d tick%0d steps_left", m, k), int'(steps_left), ns - k);
      end
      check($sformatf("rnd%0d ended", m), int'(busy), 0);
      check($sformatf("rnd%0d done", m), int'(done), int'(!exp_by_abort));
      check($sformatf("rnd%0d aborted", m), int'(aborted), int'(exp_by_abort));
      step();
    end

    // Reset in the middle of a move
    send_cmd(1'b0, 40, 3);
    wait_moving(edges);
    for (int k = 0; k < 12; k++) tick();
    check("pre-reset set_rate", int'(set_rate), 1);
    #2;
    rst = 1'b0;
    #1;
    check("midreset cmd_ready", int'(cmd_ready), 1);
    check("midreset rot_en", int'(rot_en), 0);
    check("midreset rot_dir", int'(rot_dir), 0);
    check("midreset set_rate", int'(set_rate), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset aborted", int'(aborted), 0);
    check("midreset steps_left", int'(steps_left), 0);
    step();
    rst = 1'b1;
    last_dir_m = 1'b0;
    step();
    check("post-reset busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
